// File: rtl/mcycle_sequencer_if.sv
// Sequencer bus bundle between the control unit and mcycle_sequencer.
//   master : control-unit side. Drives enable/wait/fetch/halt/stop/wake and
//            observes the timing vectors and status.
//   slave  : the sequencer itself.
// Signal names keep the i_/o_ prefixes as seen from the sequencer.
interface mcycle_sequencer_if #(
  parameter int MAX_MCYCLES = 8
);
  logic                   i_Enable;
  logic                   i_Wait;
  logic                   i_IR_Fetch;
  logic                   i_Halt;
  logic                   i_Stop;
  logic                   i_Wake;
  logic [3:0]             o_Cycle_Step;
  logic [MAX_MCYCLES-1:0] o_Cycle_Count;
  logic                   o_Active;
  logic                   o_IR_Load;
  logic                   o_Stopped;
  logic                   o_Overrun;
  logic [1:0]             o_State;

  modport master (
    output i_Enable, i_Wait, i_IR_Fetch, i_Halt, i_Stop, i_Wake,
    input  o_Cycle_Step, o_Cycle_Count, o_Active, o_IR_Load,
           o_Stopped, o_Overrun, o_State
  );

  modport slave (
    input  i_Enable, i_Wait, i_IR_Fetch, i_Halt, i_Stop, i_Wake,
    output o_Cycle_Step, o_Cycle_Count, o_Active, o_IR_Load,
           o_Stopped, o_Overrun, o_State
  );
endinterface

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: T-state / M-cycle timing generator for the CPU control
// unit, plus HALT/STOP low-power states and bus-wait stalls.
// Ports:
//   i_Clk      CPU clock
//   i_Reset_n  asynchronous active-low reset
//   bus        mcycle_sequencer_if.slave
//     in : i_Enable (tick enable), i_Wait (bus stall), i_IR_Fetch (microcode
//          fetch request), i_Halt / i_Stop (decoded opcode), i_Wake
//     out: o_Cycle_Step (one-hot T1..T4), o_Cycle_Count (one-hot M1..Mn),
//          o_Active (RUN), o_IR_Load (comb IR strobe), o_Stopped (STOP),
//          o_Overrun (sticky count wrap), o_State (00 BOOT 01 RUN 10 HALT
//          11 STOP)
module mcycle_sequencer #(
  parameter int MAX_MCYCLES = 8
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  mcycle_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  localparam logic [3:0]             T1 = 4'b0001;
  localparam logic [MAX_MCYCLES-1:0] M1 = {{(MAX_MCYCLES-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [3:0]             step_q, step_d;
  logic [MAX_MCYCLES-1:0] count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic                   adv;
  logic                   at_t4;
  logic                   ir_load;

  // A tick only moves the T-state when running and the bus is not stalled.
  assign adv     = bus.i_Enable & ~bus.i_Wait & (state_q == ST_RUN);
  assign at_t4   = step_q[3];
  // Opcode lands in IR on the closing T4 of the fetch M-cycle.
  assign ir_load = adv & at_t4 & bus.i_IR_Fetch;

  // State register. i_Enable gates every update, so a low enable freezes
  // the whole sequencer regardless of what the next-state logic proposes.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_BOOT;
      step_q    <= T1;
      count_q   <= M1;
      overrun_q <= 1'b0;
    end else if (bus.i_Enable) begin
      state_q   <= state_d;
      step_q    <= step_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_BOOT: begin
        // First enabled tick starts the opcode fetch at M1/T1.
        state_d = ST_RUN;
        step_d  = T1;
        count_d = M1;
      end
      ST_RUN: begin
        if (adv) begin
          step_d = {step_q[2:0], step_q[3]};
          if (at_t4) begin
            if (bus.i_IR_Fetch) begin
              count_d = M1;
              // STOP outranks HALT when both decode at the same fetch.
              if (bus.i_Stop)      state_d = ST_STOP;
              else if (bus.i_Halt) state_d = ST_HALT;
            end else if (count_q[MAX_MCYCLES-1]) begin
              // Microcode ran past the last M-cycle without fetching:
              // restart the count and flag it until reset.
              count_d   = M1;
              overrun_d = 1'b1;
            end else begin
              count_d = {count_q[MAX_MCYCLES-2:0], 1'b0};
            end
          end
        end
      end
      ST_HALT, ST_STOP: begin
        // Park at T1/M1 so the resume starts a clean fetch. Wake on the
        // entry tick is not seen here, so the low-power state lasts at
        // least one tick.
        step_d  = T1;
        count_d = M1;
        if (bus.i_Wake) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
        step_d  = T1;
        count_d = M1;
      end
    endcase
  end

  assign bus.o_Cycle_Step  = step_q;
  assign bus.o_Cycle_Count = count_q;
  assign bus.o_Active      = (state_q == ST_RUN);
  assign bus.o_IR_Load     = ir_load;
  assign bus.o_Stopped     = (state_q == ST_STOP);
  assign bus.o_Overrun     = overrun_q;
  assign bus.o_State       = state_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer. Each tick: drive inputs after the
// falling edge, check the combinational IR strobe, push the expected
// post-edge outputs, then pop and compare them after the rising edge.
module tb_mcycle_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    string      tag;
    logic [3:0] step;
    logic [7:0] count;
    logic       active;
    logic       stopped;
    logic       overrun;
    logic [1:0] state;
  } exp_t;

  exp_t sb[$];

  mcycle_sequencer_if #(.MAX_MCYCLES(8)) bus ();

  mcycle_sequencer #(.MAX_MCYCLES(8)) dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wt, input logic fe,
                       input logic ha, input logic st, input logic wk);
    bus.i_Enable   = en;
    bus.i_Wait     = wt;
    bus.i_IR_Fetch = fe;
    bus.i_Halt     = ha;
    bus.i_Stop     = st;
    bus.i_Wake     = wk;
  endtask

  task automatic push(input string tag, input logic [3:0] s, input logic [7:0] c,
                      input logic a, input logic sp, input logic ov, input logic [1:0] state);
    exp_t e;
    e.tag = tag; e.step = s; e.count = c; e.active = a;
    e.stopped = sp; e.overrun = ov; e.state = state;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".step"},    {4'b0, bus.o_Cycle_Step}, {4'b0, e.step});
    cmp({e.tag, ".count"},   bus.o_Cycle_Count,        e.count);
    cmp({e.tag, ".active"},  {7'b0, bus.o_Active},     {7'b0, e.active});
    cmp({e.tag, ".stopped"}, {7'b0, bus.o_Stopped},    {7'b0, e.stopped});
    cmp({e.tag, ".overrun"}, {7'b0, bus.o_Overrun},    {7'b0, e.overrun});
    cmp({e.tag, ".state"},   {6'b0, bus.o_State},      {6'b0, e.state});
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic tick(input string tag, input logic ld,
                      input logic [3:0] s, input logic [7:0] c,
                      input logic a, input logic sp, input logic ov, input logic [1:0] state);
    #1;
    cmp({tag, ".ir_load"}, {7'b0, bus.o_IR_Load}, {7'b0, ld});
    push(tag, s, c, a, sp, ov, state);
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] es;
    logic [7:0] ec;
    logic       fe;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);

    // Reset values while reset is held.
    #1;
    cmp("reset.ir_load", {7'b0, bus.o_IR_Load}, 8'h00);
    push("reset", 4'h1, 8'h01, 0, 0, 0, 2'b00);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;

    // BOOT holds without enable, then enters RUN.
    drive(0, 0, 0, 0, 0, 0);
    tick("boot_hold", 0, 4'h1, 8'h01, 0, 0, 0, 2'b00);
    drive(1, 0, 0, 0, 0, 0);
    tick("boot", 0, 4'h1, 8'h01, 1, 0, 0, 2'b01);

    // Free run without fetch: full wrap through M8 sets overrun, which then
    // sticks. Stop at M2/T3 (p=38).
    for (int p = 1; p <= 38; p++) begin
      es = 4'(1 << (p % 4));
      ec = 8'(1 << ((p / 4) % 8));
      tick($sformatf("run_p%0d", p), 0, es, ec, 1, 0, (p >= 32), 2'b01);
    end

    // Async reset at M2/T3: outputs return before the next rising edge.
    drive(1, 0, 1, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst.ir_load", {7'b0, bus.o_IR_Load}, 8'h00);
    push("async_rst", 4'h1, 8'h01, 0, 0, 0, 2'b00);
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    tick("boot2", 0, 4'h1, 8'h01, 1, 0, 0, 2'b01);

    // POP: three M-cycles, fetch requested only during M3.
    for (int q = 0; q < 12; q++) begin
      fe = (q / 4 == 2);
      drive(1, 0, fe, 0, 0, 0);
      es = 4'(1 << ((q + 1) % 4));
      ec = (q == 11) ? 8'h01 : 8'(1 << ((q + 1) / 4));
      tick($sformatf("pop_q%0d", q), fe && (q % 4 == 3), es, ec, 1, 0, 0, 2'b01);
    end

    // Advance to M2/T2.
    drive(1, 0, 0, 0, 0, 0);
    for (int p = 1; p <= 5; p++) begin
      tick($sformatf("adv_p%0d", p), 0, 4'(1 << (p % 4)), 8'(1 << (p / 4)), 1, 0, 0, 2'b01);
    end

    // Bus wait for three ticks freezes M2/T2.
    drive(1, 1, 0, 0, 0, 0);
    for (int w = 0; w < 3; w++)
      tick($sformatf("wait%0d", w), 0, 4'h2, 8'h02, 1, 0, 0, 2'b01);
    drive(1, 0, 0, 0, 0, 0);
    tick("wait_release", 0, 4'h4, 8'h02, 1, 0, 0, 2'b01);

    // Enable low also freezes.
    drive(0, 0, 1, 0, 0, 0);
    tick("noen0", 0, 4'h4, 8'h02, 1, 0, 0, 2'b01);
    tick("noen1", 0, 4'h4, 8'h02, 1, 0, 0, 2'b01);
    drive(1, 0, 0, 0, 0, 0);
    tick("to_t4", 0, 4'h8, 8'h02, 1, 0, 0, 2'b01);

    // Fetch at T4 is suppressed by wait and by enable low.
    drive(1, 1, 1, 1, 0, 0);
    tick("t4_wait", 0, 4'h8, 8'h02, 1, 0, 0, 2'b01);
    drive(0, 0, 1, 1, 0, 0);
    tick("t4_noen", 0, 4'h8, 8'h02, 1, 0, 0, 2'b01);

    // Fetch end with HALT; wake on the entry tick does not prevent entry.
    drive(1, 0, 1, 1, 0, 1);
    tick("halt_enter", 1, 4'h1, 8'h01, 0, 0, 0, 2'b10);
    drive(1, 1, 0, 0, 0, 0);
    tick("halt_hold", 0, 4'h1, 8'h01, 0, 0, 0, 2'b10);
    drive(0, 0, 0, 0, 0, 1);
    tick("halt_noen", 0, 4'h1, 8'h01, 0, 0, 0, 2'b10);
    drive(1, 0, 0, 0, 0, 1);
    tick("halt_wake", 0, 4'h1, 8'h01, 1, 0, 0, 2'b01);

    // Back to T4, then HALT and STOP together: STOP wins.
    drive(1, 0, 0, 0, 0, 0);
    tick("r_t2", 0, 4'h2, 8'h01, 1, 0, 0, 2'b01);
    tick("r_t3", 0, 4'h4, 8'h01, 1, 0, 0, 2'b01);
    tick("r_t4", 0, 4'h8, 8'h01, 1, 0, 0, 2'b01);
    drive(1, 0, 1, 1, 1, 0);
    tick("stop_enter", 1, 4'h1, 8'h01, 0, 1, 0, 2'b11);
    drive(1, 0, 0, 0, 0, 0);
    tick("stop_hold", 0, 4'h1, 8'h01, 0, 1, 0, 2'b11);
    drive(0, 0, 0, 0, 0, 1);
    tick("stop_noen", 0, 4'h1, 8'h01, 0, 1, 0, 2'b11);
    drive(1, 0, 0, 0, 0, 1);
    tick("stop_wake", 0, 4'h1, 8'h01, 1, 0, 0, 2'b01);

    cmp("sb_drained", 8'(sb.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
